// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: state enum, instruction field codes
// and datapath select values.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXECUTE,
        ALUWB,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        BRANCH,
        ILLEGAL
    } statetype;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] IMM_ZE13 = 2'b00;
    localparam logic [1:0] IMM_SE13 = 2'b01;
    localparam logic [1:0] IMM_BR   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] COND_AL = 2'b00;
    localparam logic [1:0] COND_EQ = 2'b01;
    localparam logic [1:0] COND_NE = 2'b10;
    localparam logic [1:0] COND_LT = 2'b11;

    // Arithmetic DP ops and memory offsets are signed; logical ops take a zero-extended immediate.
    function automatic logic [1:0] imm_src(input logic [1:0] op, input logic [1:0] cmd);
        logic [1:0] r;
        r = IMM_ZE13;
        case (op)
            OP_DP:   r = (cmd == ALU_ADD || cmd == ALU_SUB) ? IMM_SE13 : IMM_ZE13;
            OP_MEM:  r = IMM_SE13;
            OP_BR:   r = IMM_BR;
            default: r = IMM_ZE13;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Branch condition evaluation against the registered N/Z flags.
module cond_check
    import ctrl_pkg::*;
(
    input  logic [1:0] cond,
    input  logic       n,
    input  logic       z,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_LT: taken = n;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle main controller: one state per cycle, drives datapath selects and enables,
// holds N/Z flags and stalls on MemReady in the memory-access states.
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE  | dispatch on opcode
// EXECUTE | DP operation, optional flag update
// ALUWB   | write ALU result to register file
// MEMADR  | compute effective address
// MEMRD   | load access, waits for MemReady
// MEMWB   | write load data to register file
// MEMWR   | store access, waits for MemReady
// BRANCH  | compute target, load PC if condition holds
// ILLEGAL | undefined opcode trap, left only by reset
module control_fsm
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [1:0]  ALUFlags,
    input  logic        MemReady,
    output logic        MemReq,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic        Illegal
);

    statetype   state;
    logic [1:0] flags;
    logic [1:0] op;
    logic [1:0] cmd;
    logic [1:0] cond;
    logic       i_bit;
    logic       s_bit;
    logic       l_bit;
    logic       taken;
    logic       unused_instr;

    assign op           = Instr[31:30];
    assign i_bit        = Instr[29];
    assign l_bit        = Instr[29];
    assign cond         = Instr[29:28];
    assign cmd          = Instr[26:25];
    assign s_bit        = Instr[24];
    assign unused_instr = ^{Instr[27], Instr[23:0]};

    cond_check u_cond_check (
        .cond  (cond),
        .n     (flags[1]),
        .z     (flags[0]),
        .taken (taken)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            flags <= 2'b00;
        end else begin
            case (state)
                FETCH:   if (MemReady) state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_DP:   state <= EXECUTE;
                        OP_MEM:  state <= MEMADR;
                        OP_BR:   state <= BRANCH;
                        default: state <= ILLEGAL;
                    endcase
                end
                EXECUTE: begin
                    if (s_bit) flags <= ALUFlags;
                    state <= ALUWB;
                end
                ALUWB:   state <= FETCH;
                MEMADR:  state <= l_bit ? MEMRD : MEMWR;
                MEMRD:   if (MemReady) state <= MEMWB;
                MEMWB:   state <= FETCH;
                MEMWR:   if (MemReady) state <= FETCH;
                BRANCH:  state <= FETCH;
                ILLEGAL: state <= ILLEGAL;
                default: state <= ILLEGAL;
            endcase
        end
    end

    always_comb begin
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUControl = ALU_ADD;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = imm_src(op, cmd);
        Illegal    = 1'b0;
        case (state)
            FETCH: begin
                MemReq    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            EXECUTE: begin
                ALUSrcB    = i_bit ? SRCB_IMM : SRCB_REG;
                ALUControl = cmd;
            end
            ALUWB:   RegWrite = 1'b1;
            MEMADR:  ALUSrcB = SRCB_IMM;
            MEMRD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                RegWrite  = 1'b1;
                ResultSrc = RES_RDATA;
            end
            MEMWR: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                PCWrite   = taken;
            end
            ILLEGAL: Illegal = 1'b1;
            default: Illegal = 1'b0;
        endcase
        // The state register already sits in FETCH during reset; keep its strobes quiet.
        if (reset) begin
            MemReq   = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Table-driven, scoreboarded check of the multicycle controller outputs cycle by cycle.
module tb_control_fsm;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [1:0]  ALUFlags;
    logic        MemReady;
    logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, Illegal;
    logic [1:0]  ALUSrcB, ALUControl, ResultSrc, ImmSrc;

    control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .MemReady   (MemReady),
        .MemReq     (MemReq),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  flags;
        logic        rdy;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] sb_q[$];
    string       sb_n[$];
    int          n_vec;
    int          n_miss;

    function automatic logic [15:0] ev(input logic mr, input logic mw, input logic adr,
                                       input logic ir, input logic pc, input logic rw,
                                       input logic sa, input logic [1:0] srcb,
                                       input logic [1:0] ac, input logic [1:0] rs,
                                       input logic [1:0] is, input logic il);
        return {mr, mw, adr, ir, pc, rw, sa, srcb, ac, rs, is, il};
    endfunction

    function automatic logic [15:0] outs();
        return {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA,
                ALUSrcB, ALUControl, ResultSrc, ImmSrc, Illegal};
    endfunction

    function automatic void add(input logic [31:0] instr, input logic [1:0] flags,
                                input logic rdy, input logic [15:0] exp, input string name);
        vec_t v;
        v.instr = instr; v.flags = flags; v.rdy = rdy; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endfunction

    task automatic check_now();
        logic [15:0] e;
        string       nm;
        logic [15:0] a;
        e  = sb_q.pop_front();
        nm = sb_n.pop_front();
        a  = outs();
        n_vec++;
        if (a !== e) begin
            n_miss++;
            $display("FAIL %s: outputs got %b expected %b", nm, a, e);
        end
    endtask

    // Drive one cycle's inputs just after the edge, compare on the falling edge.
    task automatic step(input logic [31:0] instr, input logic [1:0] flags, input logic rdy,
                        input logic [15:0] exp, input string name);
        Instr = instr; ALUFlags = flags; MemReady = rdy;
        sb_q.push_back(exp);
        sb_n.push_back(name);
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADDI = 32'h2100_0005;
    localparam logic [31:0] I_ANDI = 32'h2400_0000;
    localparam logic [31:0] I_BEQ  = 32'h9000_0010;
    localparam logic [31:0] I_BNE  = 32'hA000_0010;
    localparam logic [31:0] I_BLT  = 32'hB000_0000;
    localparam logic [31:0] I_LDR  = 32'h6000_0000;
    localparam logic [31:0] I_STR  = 32'h4000_0000;
    localparam logic [31:0] I_SUBS = 32'h0300_0000;
    localparam logic [31:0] I_UND  = 32'hC000_0000;

    initial begin
        n_vec = 0; n_miss = 0;
        reset = 1'b1; Instr = I_ADDI; ALUFlags = 2'b00; MemReady = 1'b1;

        // FETCH with memory ready / stalled, per ImmSrc
        add(I_ADDI, 2'b00, 1, ev(1,0,0,1,1,0,1,2'b10,2'b00,2'b10,2'b01,0), "addi_fetch");
        add(I_ADDI, 2'b00, 1, ev(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b01,0), "addi_decode");
        add(I_ADDI, 2'b01, 1, ev(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b01,0), "addi_exec");
        add(I_ADDI, 2'b00, 1, ev(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b01,0), "addi_wb");
        add(I_ANDI, 2'b00, 1, ev(1,0,0,1,1,0,1,2'b10,2'b00,2'b10,2'b00,0), "andi_fetch");
        add(I_ANDI, 2'b00, 1, ev(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0), "andi_decode");
        add(I_ANDI, 2'b11, 1, ev(0,0,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,0), "andi_exec");
        add(I_ANDI, 2'b00, 1, ev(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,0), "andi_wb");
        // flags are 01 (Z): BEQ taken, BNE not, live ALUFlags contradict
        add(I_BEQ,  2'b00, 1, ev(1,0,0,1,1,0,1,2'b10,2'b00,2'b10,2'b10,0), "beq_fetch");
        add(I_BEQ,  2'b00, 1, ev(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b10,0), "beq_decode");
        add(I_BEQ,  2'b00, 0, ev(0,0,0,0,1,0,1,2'b01,2'b00,2'b10,2'b10,0), "beq_branch");
        add(I_BNE,  2'b00, 1, ev(1,0,0,1,1,0,1,2'b10,2'b00,2'b10,2'b10,0), "bne_fetch");
        add(I_BNE,  2'b00, 1, ev(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b10,0), "bne_decode");
        add(I_BNE,  2'b00, 1, ev(0,0,0,0,0,0,1,2'b01,2'b00,2'b10,2'b10,0), "bne_branch");
        add(I_LDR,  2'b00, 1, ev(1,0,0,1,1,0,1,2'b10,2'b00,2'b10,2'b01,0), "ldr_fetch");
        add(I_LDR,  2'b00, 0, ev(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b01,0), "ldr_decode");
        add(I_LDR,  2'b00, 0, ev(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b01,0), "ldr_memadr");
        add(I_LDR,  2'b00, 0, ev(1,0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b01,0), "ldr_memrd_stall1");
        add(I_LDR,  2'b00, 0, ev(1,0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b01,0), "ldr_memrd_stall2");
        add(I_LDR,  2'b00, 1, ev(1,0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b01,0), "ldr_memrd_done");
        add(I_LDR,  2'b00, 0, ev(0,0,0,0,0,1,0,2'b00,2'b00,2'b01,2'b01,0), "ldr_memwb");
        add(I_SUBS, 2'b00, 1, ev(1,0,0,1,1,0,1,2'b10,2'b00,2'b10,2'b01,0), "subs_fetch");
        add(I_SUBS, 2'b00, 1, ev(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b01,0), "subs_decode");
        add(I_SUBS, 2'b10, 1, ev(0,0,0,0,0,0,0,2'b00,2'b01,2'b00,2'b01,0), "subs_exec");
        add(I_SUBS, 2'b00, 1, ev(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b01,0), "subs_wb");
        // flags now 10 (N): BLT taken, BEQ not taken despite live Z
        add(I_BLT,  2'b00, 1, ev(1,0,0,1,1,0,1,2'b10,2'b00,2'b10,2'b10,0), "blt_fetch");
        add(I_BLT,  2'b00, 1, ev(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b10,0), "blt_decode");
        add(I_BLT,  2'b00, 1, ev(0,0,0,0,1,0,1,2'b01,2'b00,2'b10,2'b10,0), "blt_branch");
        add(I_BEQ,  2'b00, 1, ev(1,0,0,1,1,0,1,2'b10,2'b00,2'b10,2'b10,0), "beq2_fetch");
        add(I_BEQ,  2'b00, 1, ev(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b10,0), "beq2_decode");
        add(I_BEQ,  2'b01, 1, ev(0,0,0,0,0,0,1,2'b01,2'b00,2'b10,2'b10,0), "beq2_branch");
        add(I_STR,  2'b00, 0, ev(1,0,0,0,0,0,1,2'b10,2'b00,2'b10,2'b01,0), "str_fetch_stall");
        add(I_STR,  2'b00, 1, ev(1,0,0,1,1,0,1,2'b10,2'b00,2'b10,2'b01,0), "str_fetch");
        add(I_STR,  2'b00, 1, ev(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b01,0), "str_decode");
        add(I_STR,  2'b00, 1, ev(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b01,0), "str_memadr");
        add(I_STR,  2'b00, 1, ev(1,1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b01,0), "str_memwr");

        // Reset held: strobes quiet
        #2;
        sb_q.push_back(ev(0,0,0,0,0,0,1,2'b10,2'b00,2'b10,2'b01,0));
        sb_n.push_back("reset_held");
        check_now();
        @(negedge clk);
        reset = 1'b0; MemReady = 1'b0;
        #1;
        sb_q.push_back(ev(1,0,0,0,0,0,1,2'b10,2'b00,2'b10,2'b01,0));
        sb_n.push_back("post_reset_fetch");
        check_now();
        @(posedge clk);
        #1;

        foreach (tbl[k]) step(tbl[k].instr, tbl[k].flags, tbl[k].rdy, tbl[k].exp, tbl[k].name);

        // Reset mid-store: MemWrite must drop immediately
        step(I_STR, 2'b00, 1, ev(1,0,0,1,1,0,1,2'b10,2'b00,2'b10,2'b01,0), "rst_str_fetch");
        step(I_STR, 2'b00, 1, ev(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b01,0), "rst_str_decode");
        step(I_STR, 2'b00, 1, ev(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,2'b01,0), "rst_str_memadr");
        step(I_STR, 2'b00, 0, ev(1,1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b01,0), "rst_str_memwr");
        reset = 1'b1;
        #1;
        sb_q.push_back(ev(0,0,0,0,0,0,1,2'b10,2'b00,2'b10,2'b01,0));
        sb_n.push_back("rst_abort_memwr");
        check_now();
        @(negedge clk);
        reset = 1'b0;
        #1;
        sb_q.push_back(ev(1,0,0,0,0,0,1,2'b10,2'b00,2'b10,2'b01,0));
        sb_n.push_back("rst_release_fetch");
        check_now();
        @(posedge clk);
        #1;
        // Flags were N=1 before reset; BLT must now fall through
        step(I_BLT, 2'b00, 1, ev(1,0,0,1,1,0,1,2'b10,2'b00,2'b10,2'b10,0), "rst_blt_fetch");
        step(I_BLT, 2'b00, 1, ev(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b10,0), "rst_blt_decode");
        step(I_BLT, 2'b10, 1, ev(0,0,0,0,0,0,1,2'b01,2'b00,2'b10,2'b10,0), "rst_blt_branch");

        // Undefined opcode traps and stays trapped
        step(I_UND, 2'b00, 1, ev(1,0,0,1,1,0,1,2'b10,2'b00,2'b10,2'b00,0), "und_fetch");
        step(I_UND, 2'b00, 1, ev(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0), "und_decode");
        for (int c = 0; c < 20; c++)
            step(I_UND, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ev(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1), "und_illegal_hold");
        reset = 1'b1;
        #1;
        sb_q.push_back(ev(0,0,0,0,0,0,1,2'b10,2'b00,2'b10,2'b00,0));
        sb_n.push_back("und_reset_clear");
        check_now();
        @(negedge clk);
        reset = 1'b0; MemReady = 1'b1;
        #1;
        sb_q.push_back(ev(1,0,0,1,1,0,1,2'b10,2'b00,2'b10,2'b00,0));
        sb_n.push_back("und_after_reset_fetch");
        check_now();

        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle main controller for the processor datapath. Decodes the instruction register and, one state per cycle, drives every datapath select and write enable. This includes ImmSrc to the immediate-extension unit: 13-bit zero-extend, 13-bit sign-extend, or 18-bit branch offset sign-extended and shifted left by 2. It also holds the N/Z condition flags and stalls on a memory ready handshake.

## Interface
Parameters: none.

Clock and reset:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.

Inputs:
- Instr  in  32  current instruction register contents.
- ALUFlags  in  2  {N,Z} from the ALU result in the current cycle.
- MemReady  in  1  memory completes the access this cycle.

Outputs:
- MemReq  out  1  memory access requested.
- MemWrite  out  1  store strobe.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  load the PC.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU operand A: 0 = register A, 1 = PC.
- ALUSrcB  out  2  ALU operand B: 00 = register B, 01 = ExtImm, 10 = constant 4.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result.
- ImmSrc  out  2  00 zero-extend 13, 01 sign-extend 13, 10 branch offset.
- Illegal  out  1  trapped on an undefined opcode.

## Operation
Instruction fields:
- Op = Instr[31:30]: 00 DP, 01 MEM, 10 BR, 11 undefined.
- DP: I = Instr[29], cmd = Instr[26:25] (maps directly to ALUControl), S = Instr[24].
- MEM: L = Instr[29] (1 load, 0 store).
- BR: cond = Instr[29:28]: 00 always, 01 EQ (Z=1), 10 NE (Z=0), 11 LT (N=1).

ImmSrc is decoded from Instr in every state:
- DP with cmd ADD or SUB: 01.
- DP with cmd AND or OR: 00.
- MEM: 01.
- BR: 10.
- Undefined opcode: 00.

States, with non-default outputs listed. All enables default to 0.
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. IRWrite and PCWrite are set only in the cycle MemReady=1. Next state is DECODE on MemReady, otherwise stay in FETCH.
- DECODE: next state is EXECUTE (DP), MEMADR (MEM), BRANCH (BR), or ILLEGAL (Op=11).
- EXECUTE: ALUSrcA=0, ALUSrcB = I ? 01 : 00, ALUControl=cmd. If S=1, flags ← ALUFlags at the clock edge. Next state is ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00. Next state is FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next state is MEMRD if L=1, else MEMWR.
- MEMRD: MemReq=1, AdrSrc=1. Next state is MEMWB on MemReady, otherwise hold.
- MEMWB: RegWrite=1, ResultSrc=01. Next state is FETCH.
- MEMWR: MemReq=1, MemWrite=1, AdrSrc=1. Next state is FETCH on MemReady, otherwise hold.
- BRANCH: ALUSrcA=1, ALUSrcB=01, ADD, ResultSrc=10, PCWrite = condition met. Next state is FETCH. The branch target is (PC+4) + sext(off18)<<2.
- ILLEGAL: Illegal=1, all enables 0. This state is absorbing and is left only by reset.

Flags:
- The flag register is 2 bits.
- It is written only in EXECUTE with S=1.
- BRANCH evaluates the registered flags, never the live ALUFlags.

## Timing
Reset:
- State resets to FETCH and flags to 00.
- While reset is high, MemReq, MemWrite, IRWrite, PCWrite and RegWrite are forced to 0 and Illegal is 0.
- After release, FETCH values apply from the first cycle.
- Reset asserted mid-instruction aborts it immediately. No partial write occurs after the assertion edge.

Outputs are Moore outputs (functions of state plus Instr/flags). The exception is the FETCH IRWrite/PCWrite pair, which is gated by the same-cycle MemReady.

Latency with MemReady tied high:
- DP: 4 cycles.
- Load: 5 cycles.
- Store: 4 cycles.
- Branch: 3 cycles.

Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. During such a stall, all other outputs hold their state values.

MemReady is ignored in every other state.

## Structure
- Package ctrl_pkg holds:
  - state enum statetype (FETCH … ILLEGAL);
  - Op, ALU-cmd, ImmSrc, ALUSrcB, ResultSrc and cond encodings as localparams.
- Sub-module cond_check: combinational, inputs {cond, N, Z}, output taken.
- The top module contains the state register, next-state logic, output decoder, ImmSrc decoder and flag register.

## Test plan
- Reset sequence: reset high mid-MEMWR → MemWrite=0 immediately; after release, state FETCH, flags 00, MemReq=1.
- DP ADD immediate (Op=00, I=1, cmd=00, S=1) with ALUFlags=01 in EXECUTE:
  - states follow FETCH→DECODE→EXECUTE→ALUWB;
  - ImmSrc=01, ALUSrcB=01;
  - RegWrite pulses in cycle 4;
  - flags become Z=1.
- DP AND immediate: ImmSrc=00. With S=0, flags stay unchanged despite ALUFlags=11.
- Load with MemReady low 2 cycles in MEMRD:
  - 7 cycles total;
  - ImmSrc=01, AdrSrc=1 throughout MEMRD;
  - RegWrite only in MEMWB.
- Branches:
  - BEQ after Z=1: PCWrite=1 in BRANCH, ImmSrc=10.
  - BNE with the same flags: PCWrite=0.
  - Both take 3 cycles.
- Op=11:
  - ILLEGAL entered after DECODE;
  - Illegal=1 and all enables 0 for 20 cycles regardless of MemReady;
  - reset clears it.
